// File: rtl/uart_tx_if.sv
// uart_tx_if: valid/ready word handshake feeding the UART transmitter
interface uart_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] tx_data_in;
    logic             tx_valid;
    logic             tx_ready;
    modport master (output tx_data_in, output tx_valid, input tx_ready);
    modport slave  (input tx_data_in, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: serial transmitter, frame = start, LSB-first data, even parity, stop.
// Define UART_TX_TWO_STOP_EN to append a second stop bit before returning to idle.
module uart_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic        clk,
    input  logic        rst,
    uart_tx_if.slave    bus,
    output logic        TX_data,
    output logic        tx_busy,
    output logic        tx_done
);
    localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = WIDTH > 1 ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] IDX_MAX = BW'(WIDTH - 1);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, STOP2} state_t;
    state_t           state;
    logic [CW-1:0]    clk_cnt;
    logic [BW-1:0]    bit_idx;
    logic [WIDTH-1:0] shift;
    logic [WIDTH-1:0] shift_nx;
    logic             par;
    logic             ready;
    assign shift_nx     = shift >> 1;
    assign bus.tx_ready = ready;
    assign tx_busy      = !ready;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            TX_data <= 1'b1;
            ready   <= 1'b1;
            tx_done <= 1'b0;
            clk_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
            par     <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (state == IDLE) begin
                if (bus.tx_valid) begin
                    state   <= START;
                    TX_data <= 1'b0;
                    ready   <= 1'b0;
                    shift   <= bus.tx_data_in;
                    par     <= ^bus.tx_data_in;
                end
            end else if (clk_cnt != CNT_MAX) begin
                clk_cnt <= clk_cnt + 1'b1;
            end else begin
                clk_cnt <= '0;
                case (state)
                    START: begin
                        state   <= DATA;
                        TX_data <= shift[0];
                    end
                    DATA: begin
                        if (bit_idx == IDX_MAX) begin
                            state   <= PARITY;
                            TX_data <= par;
                            bit_idx <= '0;
                        end else begin
                            shift   <= shift_nx;
                            TX_data <= shift_nx[0];
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                    PARITY: begin
                        state   <= STOP;
                        TX_data <= 1'b1;
                    end
`ifdef UART_TX_TWO_STOP_EN
                    STOP: state <= STOP2;
                    STOP2: begin
                        state   <= IDLE;
                        ready   <= 1'b1;
                        tx_done <= 1'b1;
                    end
`else
                    STOP: begin
                        state   <= IDLE;
                        ready   <= 1'b1;
                        tx_done <= 1'b1;
                    end
`endif
                    default: begin
                        state   <= IDLE;
                        TX_data <= 1'b1;
                        ready   <= 1'b1;
                    end
                endcase
            end
        end
    end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
Serial UART transmitter; the transmit end of the same framed protocol our UART receiver consumes. Frame format:
- 1 start bit (0)
- WIDTH data bits, LSB first
- 1 even-parity bit
- 1 stop bit (1)

Parallel words arrive over a valid/ready handshake and are shifted onto the line, one bit per CLKS_PER_BIT clocks. With defaults (CLKS_PER_BIT=1) the output drives our receiver directly.

Parameters:
WIDTH, 8, data bits per frame
CLKS_PER_BIT, 1, clock cycles each serial bit is held; legal range >=1

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset (single clock domain, clk)
tx_data_in  input  WIDTH  parallel word to send
tx_valid  input  1  tx_data_in is valid
tx_ready  output  1  block can accept a word
TX_data  output  WIDTH-independent 1  serial line, registered, idles high
tx_busy  output  1  frame in progress
tx_done  output  1  one-cycle pulse at frame completion

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, TX_data=1, tx_ready=1, tx_busy=0, tx_done=0
  - counters and shift register cleared
  - Reset mid-frame aborts immediately; line returns high with no partial stop bit.
- Accept: a word is accepted on the rising edge where tx_valid && tx_ready.
  - tx_data_in is latched into the shift register.
  - Parity is computed as the XOR of all data bits (even parity: total ones in data+parity is even).
- tx_ready=1 only in IDLE. tx_valid while not ready is ignored; no buffering.
- tx_busy = !tx_ready.
- States and transitions (each state holds TX_data for exactly CLKS_PER_BIT cycles, tracked by a clk_cnt counter 0..CLKS_PER_BIT-1):
  - IDLE: TX_data=1. Go to START on accept.
  - START: TX_data=0. Go to DATA.
  - DATA: TX_data=shift[0]. Shift right after each bit; bit_idx 0..WIDTH-1. Go to PARITY after bit WIDTH-1.
  - PARITY: TX_data=latched parity. Go to STOP.
  - STOP: TX_data=1. Go to IDLE; tx_done=1 for the one cycle after the last STOP cycle (same edge as entering IDLE).
- Latency: start bit is visible on TX_data the cycle after the accept edge.
- Frame length is (WIDTH+3)*CLKS_PER_BIT cycles. Next accept is possible no earlier than the first IDLE cycle, so there is a minimum 1-cycle idle-high gap between back-to-back frames.
- tx_data_in changes after accept have no effect on the frame in flight.
- Counter widths: clk_cnt is $clog2(CLKS_PER_BIT) bits, minimum 1; bit_idx is $clog2(WIDTH) bits, minimum 1. No wrap occurs beyond these terminal counts.

Optional Feature:
UART_TX_TWO_STOP_EN
- Defined: STOP is followed by a STOP2 state (TX_data=1, CLKS_PER_BIT cycles) before IDLE. Frame length becomes (WIDTH+4)*CLKS_PER_BIT, and tx_done is asserted after STOP2.
- Undefined: single stop bit as described above.

Test Plan:
- Reset: hold rst=0 for 2 cycles, then release -> TX_data=1, tx_ready=1, tx_busy=0, tx_done=0 throughout; asserting rst asynchronously between clock edges forces TX_data=1 immediately.
- Single frame, defaults: tx_data_in=8'hD7, tx_valid pulsed 1 cycle -> TX_data sequence 0,1,1,1,0,1,0,1,1,0,1 (start, LSB-first data, parity 0, stop); tx_done high one cycle after stop; tx_ready low for exactly 11 cycles.
- Parity odd-count data: tx_data_in=8'h01 -> parity bit=1; 8'h00 -> parity bit=0; 8'hFF -> parity bit=0.
- Baud divider: CLKS_PER_BIT=4, tx_data_in=8'hA5 -> each bit held exactly 4 cycles; frame 44 cycles; line sequence 0,1,0,1,0,0,1,0,1,0,1.
- Back-to-back and ignored valid: tx_valid held high with 8'h3C then 8'hC3 -> second word accepted only in the IDLE cycle after the first tx_done, with a 1-cycle high gap; a changed tx_data_in mid-frame does not alter the frame in flight.
- Reset mid-frame: assert rst during DATA bit 3 of 8'h55 -> TX_data=1 immediately, no tx_done; the next accepted word 8'h0F transmits a clean, complete frame.
